write_ptr_logic: RTL and testbench
==================================

# write_ptr_logic

Write-side pointer generator for the FIFO. It accepts write requests on `WRITE_ENA` and gates them with `FULL`. It advances a WIDTH-bit binary write counter and drives three things:

- the binary RAM write address;
- the RAM write strobe;
- the registered Gray-coded `WRITE_PTR`, which feeds `full_flag_logic` and the read-domain synchronizer.

It sits directly upstream of `full_flag_logic` and consumes that block's `FULL` output, closing the write-side loop.

## Interface
- `WIDTH`, default 8: pointer width. Bits `[WIDTH-2:0]` are the RAM address, bit `[WIDTH-1]` is the wrap bit. FIFO depth = 2^(WIDTH-1).
- `CLK`, input, 1: write-domain clock. All state changes on the rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `WRITE_ENA`, input, 1: write request from the producer, sampled at `posedge CLK`.
- `FULL`, input, 1: full flag from `full_flag_logic`.
- `WRITE_ACCEPT`, output, 1: RAM write strobe. Combinational: `WRITE_ENA & ~FULL`.
- `WRITE_ADDR`, output, WIDTH-1: binary RAM write address, registered.
- `WRITE_PTR`, output, WIDTH: Gray-coded write pointer, registered.
- `OVERFLOW`, output, 1: sticky error flag, registered. Present only with `WPTR_OVERFLOW_EN`.

## Operation
- **State:** binary counter `wbin[WIDTH-1:0]` and Gray register `wgray[WIDTH-1:0]`.
- **Accepted write:** when `WRITE_ACCEPT` = 1 at a rising edge:
  - `wbin <= wbin + 1`, modulo 2^WIDTH, carry discarded;
  - `wgray <= bin2gray(wbin + 1)`.
- **Outputs from state:** `WRITE_ADDR = wbin[WIDTH-2:0]`; `WRITE_PTR = wgray`.
- **Idle:** when `WRITE_ACCEPT` = 0, both registers hold.
- **Gray encoding:** `g = b ^ (b >> 1)`. Exactly one bit of `WRITE_PTR` changes per accepted write, including the wrap from `2^WIDTH-1` to 0.
- **Wrap bit:** `wbin[WIDTH-1]` toggles every 2^(WIDTH-1) accepted writes. `WRITE_ADDR` wraps to 0 at the same time.
- **Write while full:** `WRITE_ENA` = 1 with `FULL` = 1 means the write is dropped: no RAM strobe, no pointer change.
- **`FULL` is used as presented:** `full_flag_logic` registers `FULL`, so it lags by one edge. Early assertion is that block's responsibility; this block does not compensate.
- **Reset:** asserting `RST_N` low immediately forces `wbin`, `wgray`, `WRITE_ADDR`, `WRITE_PTR` and `OVERFLOW` to 0, independent of `CLK`.
  - A write in flight when reset asserts is lost.
  - `WRITE_ACCEPT` still follows its inputs during reset; the producer must hold `WRITE_ENA` = 0 while `RST_N` = 0.
- **Reset release:** deasserting `RST_N` takes effect at the next rising edge. `WRITE_ENA` sampled on that first edge is honoured.

## Timing
- `WRITE_ACCEPT`: zero-cycle combinational path from `WRITE_ENA` and `FULL`.
- `WRITE_ADDR` and `WRITE_PTR`: update one cycle after the accepted edge.
  - The RAM writes at `WRITE_ADDR` on the same edge the counter increments, so data lands at the pre-increment address.
- **Throughput:** one write per cycle while `FULL` = 0.
- **Timing requirement:** `WRITE_PTR` is driven directly from a flop, with no logic after the register, because it crosses clock domains.

## Configuration
- **Macro:** `WPTR_OVERFLOW_EN`.
- **Defined:**
  - `OVERFLOW` port exists.
  - `OVERFLOW` sets to 1 at the first edge where `WRITE_ENA & FULL` = 1.
  - It stays set until `RST_N` asserts.
- **Undefined:** no `OVERFLOW` port and no associated flop; behaviour is otherwise identical.

## Structure
- **Package `fifo_pkg`** holds:
  - the default `WIDTH` constant;
  - functions `bin2gray` and `gray2bin`, shared with the read-pointer logic and the empty-flag logic.
- **Sub-module `bin2gray_reg`:** parameterised WIDTH, async active-low reset, load enable. It registers the Gray value and is reused by the read-side pointer generator.
- This block contains the binary counter, the accept gating, and the optional overflow flop.

## Test plan
All scenarios use `WIDTH` = 4 (depth 8).
- **Reset:** pulse `RST_N` low mid-cycle with `wbin` = 5 -> `WRITE_PTR` = 0000, `WRITE_ADDR` = 000 and `OVERFLOW` = 0 immediately, before the next `CLK` edge.
- **Gray sequence:** 8 consecutive writes with `FULL` = 0 -> `WRITE_PTR` steps 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100. `WRITE_ADDR` steps 0..7 then 0. Check exactly one bit changes per step.
- **Full wrap:** 16 writes -> `WRITE_PTR` goes 1000 (binary 15) then 0000, and `WRITE_ADDR` returns to 000.
- **Blocked write:** `FULL` = 1 with `WRITE_ENA` = 1 for 3 cycles at `wbin` = 8 -> `WRITE_ACCEPT` = 0, `WRITE_PTR` holds 1100, and `OVERFLOW` = 1 from the first such edge with `WPTR_OVERFLOW_EN` defined.
- **Idle hold:** `WRITE_ENA` = 0 for 10 cycles -> all outputs hold their values.
- **Back-to-back:** `WRITE_ENA` held high across a `FULL` 0->1->0 toggle -> the pointer advances only on cycles where `FULL` = 0, and the accept count equals the pointer delta.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default pointer width and Gray/binary conversion
// used by the write-pointer, read-pointer and flag logic.
package fifo_pkg;

   localparam int WIDTH_DEFAULT = 8;
   localparam int CONV_W        = 32;

   // Callers cast in/out of CONV_W bits so one function serves every pointer width.
   function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
      logic [CONV_W-1:0] b;
      b[CONV_W-1] = g[CONV_W-1];
      for (int i = CONV_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/write_ptr_logic_if.sv
// Write-side FIFO bus between the producer/flag logic and write_ptr_logic.
// OVERFLOW exists only when WPTR_OVERFLOW_EN is defined.
interface write_ptr_logic_if #(
   parameter int WIDTH = fifo_pkg::WIDTH_DEFAULT
);
   logic             WRITE_ENA;
   logic             FULL;
   logic             WRITE_ACCEPT;
   logic [WIDTH-2:0] WRITE_ADDR;
   logic [WIDTH-1:0] WRITE_PTR;
`ifdef WPTR_OVERFLOW_EN
   logic             OVERFLOW;
`endif

   modport master (
      output WRITE_ENA,
      output FULL,
      input  WRITE_ACCEPT,
      input  WRITE_ADDR,
`ifdef WPTR_OVERFLOW_EN
      input  OVERFLOW,
`endif
      input  WRITE_PTR
   );

   modport slave (
      input  WRITE_ENA,
      input  FULL,
      output WRITE_ACCEPT,
      output WRITE_ADDR,
`ifdef WPTR_OVERFLOW_EN
      output OVERFLOW,
`endif
      output WRITE_PTR
   );
endinterface

// File: rtl/bin2gray_reg.sv
// Gray-code register with load enable; output comes straight from the flop so it
// can cross clock domains safely. Shared by the read- and write-pointer blocks.
module bin2gray_reg
   import fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             load,
   input  logic [WIDTH-1:0] bin_in,
   output logic [WIDTH-1:0] gray_q
);

   logic [WIDTH-1:0] gray_nxt;

   assign gray_nxt = WIDTH'(bin2gray(CONV_W'(bin_in)));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gray_q <= '0;
      end else if (load) begin
         gray_q <= gray_nxt;
      end
   end

endmodule

// File: rtl/write_ptr_logic.sv
// Write-side pointer generator: gates write requests with FULL, advances the binary
// write counter and registers its Gray image. Optional sticky OVERFLOW: WPTR_OVERFLOW_EN.
module write_ptr_logic
   import fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input logic               CLK,
   input logic               RST_N,
   write_ptr_logic_if.slave  wr
);

   logic             accept;
   logic [WIDTH-1:0] wbin;
   logic [WIDTH-1:0] wbin_nxt;
   logic [WIDTH-1:0] wgray;

   assign accept          = wr.WRITE_ENA & ~wr.FULL;
   assign wr.WRITE_ACCEPT = accept;
   assign wbin_nxt        = wbin + WIDTH'(1);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wbin <= '0;
      end else if (accept) begin
         wbin <= wbin_nxt;
      end
   end

   // Gray register loads the post-increment value so it tracks wbin in the same cycle.
   bin2gray_reg #(
      .WIDTH (WIDTH)
   ) u_wgray (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .load   (accept),
      .bin_in (wbin_nxt),
      .gray_q (wgray)
   );

   assign wr.WRITE_ADDR = wbin[WIDTH-2:0];
   assign wr.WRITE_PTR  = wgray;

`ifdef WPTR_OVERFLOW_EN
   logic overflow;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         overflow <= 1'b0;
      end else if (wr.WRITE_ENA & wr.FULL) begin
         overflow <= 1'b1;
      end
   end

   assign wr.OVERFLOW = overflow;
`endif

endmodule

// File: tb/tb_write_ptr_logic.sv
// Directed bench for write_ptr_logic at WIDTH=4 (depth 8); expected values are
// hand-computed Gray/address constants.
module tb_write_ptr_logic;

   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   acc_cnt;
   logic [W-1:0] prev_ptr;

   logic [W-1:0]   gray_lo  [8];
   logic [W-2:0]   addr_lo  [8];
   logic [W-1:0]   gray_hi  [8];
   logic [W-1:0]   gray_b2b [4];
   logic           full_b2b [6];

   write_ptr_logic_if #(.WIDTH(W)) bus ();

   write_ptr_logic #(.WIDTH(W)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .wr    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      acc_cnt  = 0;
      gray_lo  = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      addr_lo  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      gray_hi  = '{4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
      gray_b2b = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
      full_b2b = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      rst_n         = 1'b0;
      bus.WRITE_ENA = 1'b0;
      bus.FULL      = 1'b0;
      step();
      step();
      check("reset_ptr",    32'(bus.WRITE_PTR),    32'h0);
      check("reset_addr",   32'(bus.WRITE_ADDR),   32'h0);
      check("reset_accept", 32'(bus.WRITE_ACCEPT), 32'h0);
`ifdef WPTR_OVERFLOW_EN
      check("reset_ovf",    32'(bus.OVERFLOW),     32'h0);
`endif

      // Release and write on the very first edge: 8 writes, 0..7 then wrap to address 0
      rst_n         = 1'b1;
      bus.WRITE_ENA = 1'b1;
      #1;
      check("accept_comb", 32'(bus.WRITE_ACCEPT), 32'h1);
      prev_ptr = bus.WRITE_PTR;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("gray_lo[%0d]", i), 32'(bus.WRITE_PTR),  32'(gray_lo[i]));
         check($sformatf("addr_lo[%0d]", i), 32'(bus.WRITE_ADDR), 32'(addr_lo[i]));
         check($sformatf("onebit_lo[%0d]", i), 32'($countones(prev_ptr ^ bus.WRITE_PTR)), 32'h1);
         prev_ptr = bus.WRITE_PTR;
      end

      // Blocked writes at wbin=8
      bus.FULL = 1'b1;
      #1;
      check("blocked_accept", 32'(bus.WRITE_ACCEPT), 32'h0);
      step();
`ifdef WPTR_OVERFLOW_EN
      check("ovf_first_edge", 32'(bus.OVERFLOW), 32'h1);
`endif
      step();
      step();
      check("blocked_ptr",  32'(bus.WRITE_PTR),  32'hC);
      check("blocked_addr", 32'(bus.WRITE_ADDR), 32'h0);

      // Idle for 10 cycles
      bus.WRITE_ENA = 1'b0;
      bus.FULL      = 1'b0;
      #1;
      check("idle_accept", 32'(bus.WRITE_ACCEPT), 32'h0);
      for (int i = 0; i < 10; i++) step();
      check("idle_ptr",  32'(bus.WRITE_PTR),  32'hC);
      check("idle_addr", 32'(bus.WRITE_ADDR), 32'h0);
`ifdef WPTR_OVERFLOW_EN
      check("idle_ovf",  32'(bus.OVERFLOW),   32'h1);
`endif

      // Writes 9..16: pointer passes 1000 (bin 15) then wraps to 0000
      bus.WRITE_ENA = 1'b1;
      prev_ptr = bus.WRITE_PTR;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("gray_hi[%0d]", i), 32'(bus.WRITE_PTR), 32'(gray_hi[i]));
         check($sformatf("onebit_hi[%0d]", i), 32'($countones(prev_ptr ^ bus.WRITE_PTR)), 32'h1);
         prev_ptr = bus.WRITE_PTR;
      end
      check("wrap_addr", 32'(bus.WRITE_ADDR), 32'h0);

      // Back-to-back with FULL toggling 0,0,1,1,0,0: four accepts from 0
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         bus.FULL = full_b2b[i];
         #1;
         if (bus.WRITE_ACCEPT === 1'b1) acc_cnt++;
         step();
         if (acc_cnt > 0)
            check($sformatf("b2b_ptr[%0d]", i), 32'(bus.WRITE_PTR), 32'(gray_b2b[acc_cnt-1]));
      end
      check("b2b_accepts", 32'(acc_cnt),          32'd4);
      check("b2b_ptr",     32'(bus.WRITE_PTR),    32'h6);
      check("b2b_addr",    32'(bus.WRITE_ADDR),   32'h4);

      // One more write to reach wbin=5, then asynchronous reset mid-cycle
      bus.FULL = 1'b0;
      step();
      check("pre_rst_ptr",  32'(bus.WRITE_PTR),  32'h7);
      check("pre_rst_addr", 32'(bus.WRITE_ADDR), 32'h5);
      bus.WRITE_ENA = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ptr",  32'(bus.WRITE_PTR),  32'h0);
      check("async_rst_addr", 32'(bus.WRITE_ADDR), 32'h0);
`ifdef WPTR_OVERFLOW_EN
      check("async_rst_ovf",  32'(bus.OVERFLOW),   32'h0);
`endif
      @(negedge clk);
      rst_n         = 1'b1;
      bus.WRITE_ENA = 1'b1;
      step();
      check("post_rst_ptr",  32'(bus.WRITE_PTR),  32'h1);
      check("post_rst_addr", 32'(bus.WRITE_ADDR), 32'h1);
      bus.WRITE_ENA = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
